sata_dma_stream_arbiter: RTL and testbench
==========================================

# sata_dma_stream_arbiter

Two-channel packet arbiter that shares one streaming sink, the write side of the DMA resync buffer, between two DMA requesters. It grants the sink to one channel for a whole packet, from first word to `eop`. Between packets it alternates between channels round-robin. It truncates runaway packets at a configurable length, so the downstream buffer never sees an unterminated packet. The block sits in the `clk` domain, upstream of the resync buffer's `wr_*` port.

## Interface
- `DWIDTH`, 32, stream data width
- `MAXLEN`, 256, maximum words per packet (≥2); a packet reaching this length is force-terminated
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-low reset
- `in0_dat`  in  DWIDTH  channel 0 data
- `in0_eop`  in  1  channel 0 last word of packet
- `in0_val`  in  1  channel 0 valid
- `in0_rdy`  out  1  channel 0 ready
- `in1_dat`, `in1_eop`, `in1_val`, `in1_rdy`: channel 1, same as channel 0
- `out_dat`  out  DWIDTH  to resync buffer `wr_dat`
- `out_eop`  out  1  last word of packet
- `out_val`  out  1  to `wr_val`
- `out_rdy`  in  1  from `wr_rdy`
- `grant`  out  2  one-hot current owner; 00 when idle
- `trunc_err`  out  2  sticky per-channel truncation flag
- `trunc_clr`  in  1  clears `trunc_err`
- `pkt_cnt0`, `pkt_cnt1`  out  16  packets forwarded per channel (see Configuration)

## Operation
- States: IDLE, OWN0, OWN1.
- IDLE:
  - `inX_rdy`=0, `out_val`=0.
  - If exactly one `inX_val`=1, go to OWNX.
  - If both are valid, go to the channel selected by the `rr` pointer.
- OWNX:
  - `out_dat`=`inX_dat`.
  - `out_val`=`inX_val`.
  - `inX_rdy`=`out_rdy`.
  - Other channel's `rdy`=0.
  - `out_eop`=`inX_eop` OR (`len`==MAXLEN-1).
- Transfer: a cycle with `out_val` & `out_rdy` in OWNX.
  - `len` increments on each transfer.
  - `len` is $clog2(MAXLEN) bits wide and never wraps past MAXLEN-1.
- End of packet: a transfer with `out_eop`=1.
  - Next state is IDLE; `len`←0; `rr`←other channel.
  - If the end was caused by `len`==MAXLEN-1 while `inX_eop`=0, set `trunc_err[X]`. Any remaining words of that packet are arbitrated later as a new packet.
- `trunc_clr`=1 clears both flags.
  - If a set event and a clear occur in the same cycle, set wins.
- Stalls in OWNX (`inX_val`=0 or `out_rdy`=0) hold the grant indefinitely. There is no timeout.
- Data and `eop` are combinational pass-throughs; the mux select is registered state only.

## Timing
- Reset (`reset`=0 at a rising edge):
  - State IDLE, `rr`=0 (channel 0 first on a tie), `len`=0.
  - `grant`=00, `trunc_err`=00, `pkt_cnt*`=0.
  - All `rdy`/`val` are 0.
  - Reset during OWNX abandons the packet with no `eop` generated. The downstream buffer is reset alongside.
- Arbitration latency: 1 cycle in IDLE. The first word can transfer in the cycle after the request is seen.
- Back-to-back packets on one channel with the other idle: 1 IDLE bubble between packets (max throughput for 1-word packets is 1/2).
- Single-word packet (`eop` on first word): OWNX lasts exactly one cycle if `out_rdy`=1.
- `grant` reflects the state register: 01 in OWN0, 10 in OWN1.
- `inX_rdy` may depend combinationally on `out_rdy`. There is no path from `inX_val` to `inX_rdy`.

## Configuration
- `SATA_DMA_ARB_STAT_EN`:
  - Defined: `pkt_cnt0`/`pkt_cnt1` increment by 1 on each end-of-packet transfer of their channel, truncated packets included. They wrap from 0xFFFF to 0.
  - Undefined: no counter registers; `pkt_cnt0`/`pkt_cnt1` are tied to 0.

## Test plan
- Reset then idle inputs -> `grant`=00, all `rdy`/`val`=0, counters 0.
- Both channels present 3-word packets at the same time, `out_rdy`=1 -> ch0 words 0-2 then ch1 words 0-2, 1 IDLE cycle between, `grant` 01 then 10; with STAT_EN both counters read 1.
- Ch1 only, two 1-word packets back-to-back -> transfers 2 cycles apart, `rr` toggles, `in0_rdy` stays 0.
- MAXLEN=4, ch0 sends 6 words with `eop` on word 6 -> `out_eop` forced on word 4, `trunc_err`=01, words 5-6 form a second packet, `pkt_cnt0`=2; `trunc_clr` -> `trunc_err`=00.
- `out_rdy` toggles 1/0 every cycle during a 4-word ch0 packet while ch1 is requesting -> no ch1 word interleaved, ch1 granted only after ch0 `eop`, data order preserved.
- `reset` asserted mid-packet in OWN1 -> next cycle `grant`=00, `in1_rdy`=0; after release, ch0 wins a tie.

Source files
------------

// File: rtl/sata_dma_stream_arbiter.sv
// ============================================================================
// sata_dma_stream_arbiter: two-channel round-robin packet arbiter feeding the
// DMA resync buffer write port. Optional macro: SATA_DMA_ARB_STAT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sata_dma_stream_arbiter #(
  parameter int DWIDTH = 32,
  parameter int MAXLEN = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DWIDTH-1:0] in0_dat,
  input  logic              in0_eop,
  input  logic              in0_val,
  output logic              in0_rdy,
  input  logic [DWIDTH-1:0] in1_dat,
  input  logic              in1_eop,
  input  logic              in1_val,
  output logic              in1_rdy,
  output logic [DWIDTH-1:0] out_dat,
  output logic              out_eop,
  output logic              out_val,
  input  logic              out_rdy,
  output logic [1:0]        grant,
  output logic [1:0]        trunc_err,
  input  logic              trunc_clr,
  output logic [15:0]       pkt_cnt0,
  output logic [15:0]       pkt_cnt1
);

  localparam int LENW = $clog2(MAXLEN);
  localparam logic [LENW-1:0] LEN_LAST = LENW'(MAXLEN - 1);

  // Encoding chosen so the state register doubles as the one-hot grant.
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_OWN0 = 2'b01;
  localparam logic [1:0] S_OWN1 = 2'b10;

  logic [1:0]      state_q, state_d;
  logic            rr_q, rr_d;
  logic [LENW-1:0] len_q, len_d;
  logic [1:0]      trunc_q, trunc_d;
  logic            len_last, sel_eop, xfer, eop_xfer;

  assign len_last  = (len_q == LEN_LAST);
  assign xfer      = out_val & out_rdy;
  assign eop_xfer  = xfer & out_eop;
  assign grant     = state_q;
  assign trunc_err = trunc_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
      len_q   <= '0;
      trunc_q <= 2'b00;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      len_q   <= len_d;
      trunc_q <= trunc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    len_d   = len_q;
    trunc_d = trunc_clr ? 2'b00 : trunc_q;
    case (state_q)
      S_IDLE: begin
        if (in0_val && in1_val) state_d = rr_q ? S_OWN1 : S_OWN0;
        else if (in0_val)       state_d = S_OWN0;
        else if (in1_val)       state_d = S_OWN1;
      end
      S_OWN0, S_OWN1: begin
        if (eop_xfer) begin
          state_d = S_IDLE;
          len_d   = '0;
          rr_d    = (state_q == S_OWN0);
          // A forced end without the source's eop marks a truncation; set beats clear.
          if (len_last && !sel_eop) trunc_d[state_q[1]] = 1'b1;
        end else if (xfer && !len_last) begin
          len_d = len_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_dat = '0;
    out_val = 1'b0;
    sel_eop = 1'b0;
    in0_rdy = 1'b0;
    in1_rdy = 1'b0;
    case (state_q)
      S_OWN0: begin
        out_dat = in0_dat;
        out_val = in0_val;
        sel_eop = in0_eop;
        in0_rdy = out_rdy;
      end
      S_OWN1: begin
        out_dat = in1_dat;
        out_val = in1_val;
        sel_eop = in1_eop;
        in1_rdy = out_rdy;
      end
      default: ;
    endcase
    out_eop = (state_q != S_IDLE) && (sel_eop || len_last);
  end

`ifdef SATA_DMA_ARB_STAT_EN
  logic [15:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt0_q <= 16'd0;
      cnt1_q <= 16'd0;
    end else if (eop_xfer) begin
      if (state_q == S_OWN0) cnt0_q <= cnt0_q + 16'd1;
      if (state_q == S_OWN1) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;
`else
  assign pkt_cnt0 = 16'd0;
  assign pkt_cnt1 = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sata_dma_stream_arbiter.sv
// ============================================================================
// tb_sata_dma_stream_arbiter: directed scoreboard bench for the stream arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sata_dma_stream_arbiter;

  localparam int DW = 32;
  localparam int ML = 4;
`ifdef SATA_DMA_ARB_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  typedef struct packed { logic [DW-1:0] dat; logic eop; } word_t;
  typedef struct { int cyc; int ch; } xfer_t;

  logic          clk, reset;
  logic [DW-1:0] in0_dat, in1_dat, out_dat;
  logic          in0_eop, in0_val, in0_rdy, in1_eop, in1_val, in1_rdy;
  logic          out_eop, out_val, out_rdy, trunc_clr;
  logic [1:0]    grant, trunc_err;
  logic [15:0]   pkt_cnt0, pkt_cnt1;

  sata_dma_stream_arbiter #(.DWIDTH(DW), .MAXLEN(ML)) dut (
    .clk(clk), .reset(reset),
    .in0_dat(in0_dat), .in0_eop(in0_eop), .in0_val(in0_val), .in0_rdy(in0_rdy),
    .in1_dat(in1_dat), .in1_eop(in1_eop), .in1_val(in1_val), .in1_rdy(in1_rdy),
    .out_dat(out_dat), .out_eop(out_eop), .out_val(out_val), .out_rdy(out_rdy),
    .grant(grant), .trunc_err(trunc_err), .trunc_clr(trunc_clr),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  word_t       src0[$], src1[$], exp0[$], exp1[$];
  xfer_t       log_q[$];
  logic [15:0] exp_cnt[2];
  logic [1:0]  exp_trunc;
  int          total, bad, cyc;
  logic        hs0, hs1, seen_rdy0;
  int          mch, qs, t0;
  word_t       me;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Source model plus expected-output model (forced eop at the length limit).
  task automatic push_pkt(input int ch, input int n, input logic [DW-1:0] base);
    int len = 0;
    for (int i = 0; i < n; i++) begin
      word_t w, e;
      w.dat = base + DW'(i);
      w.eop = (i == n - 1);
      e.dat = w.dat;
      e.eop = w.eop || (len == ML - 1);
      if (e.eop) begin
        if (!w.eop) exp_trunc[ch] = 1'b1;
        exp_cnt[ch] = exp_cnt[ch] + 16'd1;
        len = 0;
      end else begin
        len++;
      end
      if (ch == 0) begin src0.push_back(w); exp0.push_back(e); end
      else         begin src1.push_back(w); exp1.push_back(e); end
    end
  endtask

  function automatic bit all_empty();
    return (src0.size() == 0) && (src1.size() == 0) && (exp0.size() == 0) && (exp1.size() == 0);
  endfunction

  task automatic wait_drain(input int budget, input bit toggle);
    int n = 0;
    while (!all_empty() && n < budget) begin
      @(posedge clk); #3;
      if (toggle) out_rdy = ~out_rdy;
      n++;
    end
    chk("drain", all_empty(), 1);
    out_rdy = 1'b1;
    repeat (2) begin @(posedge clk); #3; end
  endtask

  task automatic chk_counts();
    chk("pkt_cnt0", pkt_cnt0, STAT ? exp_cnt[0] : 16'd0);
    chk("pkt_cnt1", pkt_cnt1, STAT ? exp_cnt[1] : 16'd0);
  endtask

  // Sources: present queue head, pop after a handshake seen on the falling edge.
  initial begin
    in0_val = 1'b0; in0_dat = '0; in0_eop = 1'b0;
    in1_val = 1'b0; in1_dat = '0; in1_eop = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (hs0 && src0.size() > 0) void'(src0.pop_front());
      if (hs1 && src1.size() > 0) void'(src1.pop_front());
      if (src0.size() > 0) begin
        in0_val = 1'b1; in0_dat = src0[0].dat; in0_eop = src0[0].eop;
      end else begin
        in0_val = 1'b0; in0_dat = '0; in0_eop = 1'b0;
      end
      if (src1.size() > 0) begin
        in1_val = 1'b1; in1_dat = src1[0].dat; in1_eop = src1[0].eop;
      end else begin
        in1_val = 1'b0; in1_dat = '0; in1_eop = 1'b0;
      end
    end
  end

  // Monitor / scoreboard on the falling edge.
  initial begin
    hs0 = 1'b0; hs1 = 1'b0; seen_rdy0 = 1'b0;
    forever begin
      @(negedge clk);
      hs0 = in0_val & in0_rdy;
      hs1 = in1_val & in1_rdy;
      if (in0_rdy) seen_rdy0 = 1'b1;
      if (reset && grant == 2'b01) begin
        chk("own0_rdy0", in0_rdy, out_rdy);
        chk("own0_rdy1", in1_rdy, 0);
        chk("own0_val", out_val, in0_val);
      end
      if (reset && grant == 2'b10) begin
        chk("own1_rdy1", in1_rdy, out_rdy);
        chk("own1_rdy0", in0_rdy, 0);
        chk("own1_val", out_val, in1_val);
      end
      if (reset && out_val && out_rdy) begin
        mch = (grant == 2'b01) ? 0 : (grant == 2'b10) ? 1 : -1;
        chk("grant_onehot", (mch >= 0), 1);
        qs = (mch == 0) ? exp0.size() : (mch == 1) ? exp1.size() : 0;
        chk("exp_avail", (qs > 0), 1);
        if (qs > 0) begin
          me = (mch == 0) ? exp0.pop_front() : exp1.pop_front();
          chk("out_dat", out_dat, me.dat);
          chk("out_eop", out_eop, me.eop);
        end
        log_q.push_back('{cyc, mch});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    exp_cnt[0] = 16'd0; exp_cnt[1] = 16'd0; exp_trunc = 2'b00;
    reset = 1'b0; out_rdy = 1'b0; trunc_clr = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_grant", grant, 2'b00);
    chk("rst_rdy", {in0_rdy, in1_rdy}, 2'b00);
    chk("rst_val", out_val, 0);
    chk("rst_trunc", trunc_err, 2'b00);
    chk_counts();
    reset = 1'b1; out_rdy = 1'b1;
    @(posedge clk); #3;
    chk("idle_grant", grant, 2'b00);

    // Tie: ch0 first (rr=0), one IDLE bubble, then ch1.
    log_q.delete();
    t0 = cyc;
    push_pkt(0, 3, 32'hA000_0000);
    push_pkt(1, 3, 32'hB000_0000);
    wait_drain(40, 1'b0);
    chk("tie_n", log_q.size(), 6);
    if (log_q.size() == 6) begin
      chk("tie_lat", log_q[0].cyc - t0, 2);
      for (int i = 0; i < 6; i++) chk("tie_ch", log_q[i].ch, (i < 3) ? 0 : 1);
      chk("tie_b2b", log_q[2].cyc - log_q[0].cyc, 2);
      chk("tie_gap", log_q[3].cyc - log_q[2].cyc, 2);
    end
    chk_counts();

    // Ch1 back-to-back single-word packets.
    log_q.delete();
    seen_rdy0 = 1'b0;
    push_pkt(1, 1, 32'hC1);
    push_pkt(1, 1, 32'hC2);
    wait_drain(20, 1'b0);
    chk("b2b_n", log_q.size(), 2);
    if (log_q.size() == 2) chk("b2b_gap", log_q[1].cyc - log_q[0].cyc, 2);
    chk("b2b_rdy0", seen_rdy0, 0);

    // Truncation at MAXLEN, remainder forms a second packet.
    push_pkt(0, 6, 32'h40);
    wait_drain(40, 1'b0);
    chk("trunc_set", trunc_err, exp_trunc);
    chk_counts();
    trunc_clr = 1'b1;
    @(posedge clk); #3;
    trunc_clr = 1'b0;
    exp_trunc = 2'b00;
    chk("trunc_clr", trunc_err, 2'b00);

    // Back-pressure toggling with ch1 requesting during ch0's packet.
    log_q.delete();
    push_pkt(0, 4, 32'hD0);
    @(posedge clk); #3;
    push_pkt(1, 2, 32'hE0);
    wait_drain(60, 1'b1);
    chk("bp_n", log_q.size(), 6);
    if (log_q.size() == 6)
      for (int i = 0; i < 6; i++) chk("bp_ch", log_q[i].ch, (i < 4) ? 0 : 1);
    chk_counts();

    // Leave rr pointing at ch1, then reset in the middle of a ch1 packet.
    push_pkt(0, 1, 32'hF0);
    wait_drain(20, 1'b0);
    log_q.delete();
    push_pkt(1, 4, 32'h110);
    for (int n = 0; n < 20 && log_q.size() == 0; n++) begin @(posedge clk); #3; end
    chk("mid_started", (log_q.size() > 0), 1);
    reset = 1'b0;
    src1.delete(); exp1.delete();
    exp_cnt[0] = 16'd0; exp_cnt[1] = 16'd0; exp_trunc = 2'b00;
    @(posedge clk); #3;
    chk("mid_grant", grant, 2'b00);
    chk("mid_rdy1", in1_rdy, 0);
    chk("mid_val", out_val, 0);
    chk_counts();
    reset = 1'b1;
    log_q.delete();
    push_pkt(0, 1, 32'h200);
    push_pkt(1, 1, 32'h300);
    wait_drain(20, 1'b0);
    chk("post_n", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("post_ch0", log_q[0].ch, 0);
      chk("post_ch1", log_q[1].ch, 1);
    end
    chk_counts();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
